// File: rtl/data_mem_pkg.sv
// Shared types and default widths for the data-memory access path.
package data_mem_pkg;

    localparam int unsigned DEFAULT_DATA_W       = 8;
    localparam int unsigned DEFAULT_D_ADDR_WIDTH = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        RDATA = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } dmau_state_e;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } mem_op_e;

endpackage

// File: rtl/dmem_timeout_counter.sv
// Wait-state watchdog: counts enabled cycles after a clear and flags when LIMIT-1 is reached.
module dmem_timeout_counter #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturate at the limit so a late exit event never sees a wrapped count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/data_mem_access_unit.sv
// Load/store sequencer: one outstanding req/gnt/rvalid access to data memory with a timeout abort.
module data_mem_access_unit
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W         = DEFAULT_DATA_W,
    parameter int unsigned D_ADDR_WIDTH   = DEFAULT_D_ADDR_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_load,
    input  logic                    start_store,
    input  logic [D_ADDR_WIDTH-1:0] dmar,
    input  logic [DATA_W-1:0]       acc_out,
    output logic                    busy,
    output logic                    done,
    output logic                    access_err,
    output logic [DATA_W-1:0]       acc_load_data,
    output logic                    acc_load_we,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [D_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_W-1:0]       mem_rdata
);

    dmau_state_e             state_q, state_d;
    mem_op_e                 op_q, op_d;
    logic [D_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    load_we_q, load_we_d;
    logic                    req_q, req_d;
    logic                    we_q, we_d;
    logic                    cnt_clear_c, cnt_en_c, expired_c;

    dmem_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (cnt_clear_c),
        .enable_i (cnt_en_c),
        .expired_c(expired_c)
    );

    // Next-state and output decode; outputs are registered from the next state.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (start_load || start_store) begin
                    op_d    = start_load ? OP_LOAD : OP_STORE;
                    addr_d  = dmar;
                    wdata_d = acc_out;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = (op_q == OP_STORE) ? DONE : RDATA;
                end else if (expired_c) begin
                    state_d = ERR;
                end
            end
            RDATA: begin
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = DONE;
                end else if (expired_c) begin
                    state_d = ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cnt_clear_c = (state_d != state_q);
        cnt_en_c    = (state_q == REQ) || (state_q == RDATA);

        busy_d    = (state_d == REQ) || (state_d == RDATA);
        done_d    = (state_d == DONE);
        err_d     = (state_d == ERR);
        load_we_d = (state_d == DONE) && (op_d == OP_LOAD);
        req_d     = (state_d == REQ);
        we_d      = (state_d == REQ) && (op_d == OP_STORE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= OP_LOAD;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            load_we_q <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            load_we_q <= load_we_d;
            req_q     <= req_d;
            we_q      <= we_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign access_err    = err_q;
    assign acc_load_data = rdata_q;
    assign acc_load_we   = load_we_q;
    assign mem_req       = req_q;
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;

endmodule
